// File: rtl/reservoir_sequencer.sv
// rtl/reservoir_sequencer.sv - reservoir run sequencer: sample fetch, hold, neuron readout MAC, y_out emit
module reservoir_sequencer #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 16,
    parameter int W_W      = 8,
    parameter int N_NEURON = 20,
    parameter int SEL_W    = 5,
    parameter int ACC_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              src_sel,
    input  logic [ADDR_W-1:0] num_samples,
    input  logic [15:0]       t_eval,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_valid,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] res_data,
    output logic              res_load,
    output logic [SEL_W-1:0]  neuron_sel,
    input  logic [DATA_W-1:0] neuron_y,
    input  logic [W_W-1:0]    weight,
    output logic [DATA_W-1:0] y_out,
    output logic              y_valid,
    output logic              busy,
    output logic              done
);

    localparam int PROD_W = DATA_W + W_W;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_NEURON - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_HOLD,
        S_READOUT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic              src_rom;
    logic [ADDR_W-1:0] num_r;
    logic [ADDR_W-1:0] sample_cnt;
    logic [15:0]       t_eval_r;
    logic [15:0]       hold_cnt;
    logic [SEL_W-1:0]  sel_cnt;
    logic [ACC_W-1:0]  acc;

    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0] y_next;
    logic [ADDR_W:0]   cnt_inc;
    logic              last_sample;
    logic              hold_done;
    logic              sel_last;

    // Unsigned full-width product of the selected neuron and its weight.
    assign product = {{W_W{1'b0}}, neuron_y} * {{DATA_W{1'b0}}, weight};
    assign acc_sum = acc + {{(ACC_W - PROD_W){1'b0}}, product};
    // Anything at or above 2^(DATA_W+W_W) no longer fits after the shift, so clamp.
    assign y_next  = (|acc_sum[ACC_W-1:PROD_W]) ? {DATA_W{1'b1}} : acc_sum[PROD_W-1:W_W];

    assign cnt_inc     = {1'b0, sample_cnt} + {{ADDR_W{1'b0}}, 1'b1};
    assign last_sample = (cnt_inc == {1'b0, num_r});
    // hold_cnt starts at 1 on HOLD entry, so t_eval of 0 and 1 both give a single cycle.
    assign hold_done   = (hold_cnt >= t_eval_r);
    assign sel_last    = (sel_cnt == SEL_LAST);
    assign neuron_sel  = sel_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        y_valid   = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_samples == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (src_rom) begin
                    rom_en    = 1'b1;
                    state_nxt = S_WAIT_ROM;
                end else if (ext_valid) begin
                    state_nxt = S_HOLD;
                end
            end
            S_WAIT_ROM: state_nxt = S_HOLD;
            S_HOLD: begin
                if (hold_done) begin
                    state_nxt = S_READOUT;
                end
            end
            S_READOUT: begin
                if (sel_last) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                y_valid   = 1'b1;
                state_nxt = last_sample ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run parameters, sample/address counters, sample register and readout accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_rom    <= 1'b0;
            num_r      <= '0;
            t_eval_r   <= '0;
            sample_cnt <= '0;
            rom_addr   <= '0;
            res_data   <= '0;
            res_load   <= 1'b0;
            hold_cnt   <= '0;
            sel_cnt    <= '0;
            acc        <= '0;
            y_out      <= '0;
        end else begin
            res_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_rom    <= src_sel;
                        num_r      <= num_samples;
                        t_eval_r   <= t_eval;
                        rom_addr   <= '0;
                        sample_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (!src_rom && ext_valid) begin
                        res_data <= ext_data;
                        res_load <= 1'b1;
                        hold_cnt <= 16'd1;
                    end
                end
                S_WAIT_ROM: begin
                    res_data <= rom_dout;
                    res_load <= 1'b1;
                    hold_cnt <= 16'd1;
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 16'd1;
                    if (hold_done) begin
                        acc     <= '0;
                        sel_cnt <= '0;
                    end
                end
                S_READOUT: begin
                    acc <= acc_sum;
                    if (sel_last) begin
                        sel_cnt <= '0;
                        y_out   <= y_next;
                    end else begin
                        sel_cnt <= sel_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    sample_cnt <= sample_cnt + 1'b1;
                    rom_addr   <= rom_addr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// tb/tb_reservoir_sequencer.sv - randomized model-checked bench for reservoir_sequencer
module tb_reservoir_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        src_sel = 1'b0;
    logic [12:0] num_samples = '0;
    logic [15:0] t_eval = '0;
    logic [15:0] ext_data = '0;
    logic        ext_valid = 1'b0;
    logic        rom_en;
    logic [12:0] rom_addr;
    logic [15:0] rom_dout = '0;
    logic [15:0] res_data;
    logic        res_load;
    logic [4:0]  neuron_sel;
    logic [15:0] neuron_y;
    logic [7:0]  weight;
    logic [15:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        done;

    reservoir_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .src_sel(src_sel),
        .num_samples(num_samples), .t_eval(t_eval), .ext_data(ext_data),
        .ext_valid(ext_valid), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_dout(rom_dout), .res_data(res_data), .res_load(res_load),
        .neuron_sel(neuron_sel), .neuron_y(neuron_y), .weight(weight),
        .y_out(y_out), .y_valid(y_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Neuron array and ROM stand-ins
    logic [15:0] ny_tab [32];
    logic [7:0]  w_tab  [32];
    logic        xor_en = 1'b0;
    logic        rom_ident = 1'b0;

    assign neuron_y = xor_en ? (ny_tab[neuron_sel] ^ res_data) : ny_tab[neuron_sel];
    assign weight   = w_tab[neuron_sel];

    function automatic logic [15:0] rom_fn(input logic [12:0] a);
        logic [15:0] a16;
        a16 = {3'b000, a};
        return rom_ident ? a16 : ((a16 * 16'h9E37) ^ 16'h5A5A);
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_fn(rom_addr);
    end

    // Pulse counters and timestamps
    int cyc = 0, n_rom_en = 0, n_res_load = 0, n_y_valid = 0, n_done = 0;
    int rom_en_cyc = 0, done_cyc = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rom_en) begin n_rom_en <= n_rom_en + 1; rom_en_cyc <= cyc; end
        if (res_load) n_res_load <= n_res_load + 1;
        if (y_valid) n_y_valid <= n_y_valid + 1;
        if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
    end

    // Expected per-cycle trace
    typedef struct packed {
        logic        start;
        logic        ev;
        logic [15:0] ed;
        logic        rom_en;
        logic [12:0] rom_addr;
        logic [15:0] res_data;
        logic        res_load;
        logic [4:0]  sel;
        logic [15:0] y_out;
        logic        y_valid;
        logic        busy;
        logic        done;
        logic        ro;
    } rec_t;

    rec_t q[$];
    logic [12:0] m_rom_addr = '0;
    logic [15:0] m_res_data = '0;
    logic [15:0] m_y_out = '0;
    logic        run_src = 1'b0;
    logic [12:0] run_ns = '0;
    logic [15:0] run_te = '0;

    int n_checks = 0, n_errors = 0;
    int start_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_rec(input logic bz, input logic re, input logic rl, input logic yv,
                            input logic dn, input logic [4:0] sel, input logic ev,
                            input logic [15:0] ed, input logic st, input logic ro);
        rec_t r;
        r.start = st; r.ev = ev; r.ed = ed;
        r.rom_en = re; r.rom_addr = m_rom_addr; r.res_data = m_res_data;
        r.res_load = rl; r.sel = sel; r.y_out = m_y_out; r.y_valid = yv;
        r.busy = bz; r.done = dn; r.ro = ro;
        q.push_back(r);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic rnd_st();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Readout result: sum of neuron*weight over all neurons, shifted and clamped.
    function automatic logic [15:0] y_model(input logic [15:0] d);
        longint sum;
        logic [15:0] v;
        sum = 0;
        for (int i = 0; i < 20; i++) begin
            v = xor_en ? (ny_tab[i] ^ d) : ny_tab[i];
            sum += longint'(v) * longint'(w_tab[i]);
        end
        if (sum >= 64'd16777216) return 16'hFFFF;
        return 16'(sum >> 8);
    endfunction

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++)
            push_rec(0, 0, 0, 0, 0, 5'd0, rnd_bit(), 16'($urandom), 1'b0, 0);
    endtask

    task automatic gen_run(input logic src, input int ns, input int te,
                           input int stall_fix, input int ed_fix);
        int hold_n, st;
        logic [15:0] d, y;
        run_src = src; run_ns = 13'(ns); run_te = 16'(te);
        hold_n = (te == 0) ? 1 : te;
        push_rec(0, 0, 0, 0, 0, 5'd0, rnd_bit(), 16'($urandom), 1'b1, 0);
        m_rom_addr = '0;
        for (int s = 0; s < ns; s++) begin
            if (src) begin
                push_rec(1, 1, 0, 0, 0, 5'd0, rnd_bit(), 16'($urandom), rnd_st(), 0);
                push_rec(1, 0, 0, 0, 0, 5'd0, rnd_bit(), 16'($urandom), rnd_st(), 0);
                d = rom_fn(m_rom_addr);
            end else begin
                st = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 4));
                d = (ed_fix >= 0) ? 16'(ed_fix) : 16'($urandom);
                for (int j = 0; j < st; j++)
                    push_rec(1, 0, 0, 0, 0, 5'd0, 1'b0, 16'($urandom), rnd_st(), 0);
                push_rec(1, 0, 0, 0, 0, 5'd0, 1'b1, d, rnd_st(), 0);
            end
            m_res_data = d;
            for (int h = 0; h < hold_n; h++)
                push_rec(1, 0, (h == 0), 0, 0, 5'd0, rnd_bit(), 16'($urandom), rnd_st(), 0);
            y = y_model(d);
            for (int i = 0; i < 20; i++)
                push_rec(1, 0, 0, 0, 0, 5'(i), rnd_bit(), 16'($urandom), rnd_st(), 1);
            m_y_out = y;
            push_rec(1, 0, 0, 1, 0, 5'd0, rnd_bit(), 16'($urandom), rnd_st(), 0);
            m_rom_addr = m_rom_addr + 13'd1;
        end
        push_rec(1, 0, 0, 0, 1, 5'd0, rnd_bit(), 16'($urandom), rnd_st(), 0);
        idle_n(3);
    endtask

    task automatic step(input rec_t r);
        @(posedge clk);
        #1;
        start = r.start;
        ext_valid = r.ev;
        ext_data = r.ed;
        if (r.start) begin
            src_sel = run_src; num_samples = run_ns; t_eval = run_te;
        end else begin
            src_sel = rnd_bit(); num_samples = 13'($urandom); t_eval = 16'($urandom);
        end
        @(negedge clk);
        if (r.start) start_cyc = cyc;
        chk("busy", 32'(busy), 32'(r.busy));
        chk("done", 32'(done), 32'(r.done));
        chk("rom_en", 32'(rom_en), 32'(r.rom_en));
        chk("rom_addr", 32'(rom_addr), 32'(r.rom_addr));
        chk("res_data", 32'(res_data), 32'(r.res_data));
        chk("res_load", 32'(res_load), 32'(r.res_load));
        chk("neuron_sel", 32'(neuron_sel), 32'(r.sel));
        chk("y_out", 32'(y_out), 32'(r.y_out));
        chk("y_valid", 32'(y_valid), 32'(r.y_valid));
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n && i < q.size(); i++) step(q[i]);
        q.delete();
    endtask

    task automatic set_tables(input logic [15:0] ny, input logic [7:0] w);
        for (int i = 0; i < 32; i++) begin ny_tab[i] = ny; w_tab[i] = w; end
    endtask

    task automatic rand_tables();
        for (int i = 0; i < 32; i++) begin
            ny_tab[i] = 16'($urandom) >> $urandom_range(0, 7);
            w_tab[i]  = 8'($urandom);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_res_data"}, 32'(res_data), 32'd0);
        chk({tag, "_res_load"}, 32'(res_load), 32'd0);
        chk({tag, "_neuron_sel"}, 32'(neuron_sel), 32'd0);
        chk({tag, "_y_out"}, 32'(y_out), 32'd0);
        chk({tag, "_y_valid"}, 32'(y_valid), 32'd0);
    endtask

    int b_rom, b_rl, b_yv, b_dn, k;

    initial begin
        set_tables(16'h0000, 8'h00);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        idle_n(2);
        play(q.size());

        // Uniform neurons: 20 * 0x100 * 1 = 0x1400, >> 8 = 0x14
        set_tables(16'h0100, 8'h01);
        xor_en = 1'b0;
        gen_run(1'b1, 1, 4, -1, -1);
        play(q.size());
        chk("t1_y_out", 32'(y_out), 32'h0014);
        chk("t1_fetch_to_done", 32'(done_cyc - rom_en_cyc), 32'd27);

        // Identity ROM, three samples
        rom_ident = 1'b1;
        xor_en = 1'b1;
        rand_tables();
        b_rom = n_rom_en; b_rl = n_res_load; b_yv = n_y_valid; b_dn = n_done;
        gen_run(1'b1, 3, 2, -1, -1);
        play(q.size());
        chk("t2_rom_en_cnt", 32'(n_rom_en - b_rom), 32'd3);
        chk("t2_res_load_cnt", 32'(n_res_load - b_rl), 32'd3);
        chk("t2_y_valid_cnt", 32'(n_y_valid - b_yv), 32'd3);
        chk("t2_done_cnt", 32'(n_done - b_dn), 32'd1);
        chk("t2_res_data", 32'(res_data), 32'd2);
        chk("t2_rom_addr", 32'(rom_addr), 32'd3);
        rom_ident = 1'b0;

        // Saturation, with t_eval=0
        set_tables(16'hFFFF, 8'hFF);
        xor_en = 1'b0;
        gen_run(1'b1, 2, 0, -1, -1);
        play(q.size());
        chk("t3_y_out_sat", 32'(y_out), 32'hFFFF);

        // External source stalled for 10 cycles
        rand_tables();
        xor_en = 1'b1;
        b_rl = n_res_load;
        gen_run(1'b0, 1, 3, 10, 16'hABCD);
        play(q.size());
        chk("t4_res_data", 32'(res_data), 32'hABCD);
        chk("t4_res_load_cnt", 32'(n_res_load - b_rl), 32'd1);

        // Empty run
        b_rom = n_rom_en; b_rl = n_res_load; b_yv = n_y_valid;
        gen_run(1'b1, 0, 5, -1, -1);
        play(q.size());
        chk("t5_start_to_done", 32'(done_cyc - start_cyc), 32'd1);
        chk("t5_rom_en_cnt", 32'(n_rom_en - b_rom), 32'd0);
        chk("t5_res_load_cnt", 32'(n_res_load - b_rl), 32'd0);
        chk("t5_y_valid_cnt", 32'(n_y_valid - b_yv), 32'd0);

        // Reset in the middle of READOUT
        rand_tables();
        gen_run(1'b1, 3, 2, -1, -1);
        k = 0;
        while (k < q.size() && !q[k].ro) k++;
        play(k + 5);
        b_dn = n_done;
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("t6_mid_reset");
        m_rom_addr = '0; m_res_data = '0; m_y_out = '0;
        idle_n(4);
        play(q.size());
        chk("t6_no_done", 32'(n_done - b_dn), 32'd0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            rand_tables();
            xor_en = rnd_bit();
            gen_run(rnd_bit(), int'($urandom_range(1, 4)), int'($urandom_range(0, 6)), -1, -1);
            play(q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
